// File: rtl/msg_defs.sv
// rtl/msg_defs.sv - shared encodings and defaults for the message transmitter arbiter
package msg_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int         MSG_W_DEFAULT        = 5;
    localparam logic [3:0] MSG_HEADER           = 4'b0101;
    localparam int         FRAME_CYCLES_DEFAULT = 10240;

endpackage

// File: rtl/msg_tx_arbiter_up_counter.sv
// rtl/msg_tx_arbiter_up_counter.sv - saturating frame timer with clear and carry-out
module msg_tx_arbiter_up_counter #(
    parameter int MAX_COUNT = 10240
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic init0,
    output logic carry
);

    localparam int CW = $clog2(MAX_COUNT + 1);

    logic [CW-1:0] count;

    // Count enabled cycles from zero; hold at MAX_COUNT instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (init0) begin
            count <= '0;
        end else if (cen && (count != CW'(MAX_COUNT))) begin
            count <= count + CW'(1);
        end
    end

    // Carry marks the last of MAX_COUNT enabled cycles
    assign carry = cen && (count == CW'(MAX_COUNT - 1));

endmodule

// File: rtl/msg_tx_arbiter.sv
// rtl/msg_tx_arbiter.sv - round-robin sequencer sharing one message transmitter
module msg_tx_arbiter
    import msg_defs::*;
#(
    parameter int N_REQ        = 4,
    parameter int MSG_W        = MSG_W_DEFAULT,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*MSG_W-1:0] msg_in,
    output logic                   send,
    output logic [MSG_W-1:0]       msg_out,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic                   busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    pick;
    logic             pick_valid;
    logic [N_REQ-1:0] pick_onehot;
    logic [MSG_W-1:0] pick_msg;
    logic             frame_done;

    // Round-robin search: first requester at or above the pointer, wrapping
    always_comb begin
        logic [IW:0]   sum;
        logic [IW-1:0] cand;
        pick       = ptr;
        pick_valid = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            cand = sum[IW-1:0];
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Decode the winner into a one-hot grant and select its payload slice
    always_comb begin
        pick_onehot = '0;
        pick_msg    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IW'(i)) begin
                pick_onehot[i] = 1'b1;
                pick_msg       = msg_in[i*MSG_W +: MSG_W];
            end
        end
    end

    msg_tx_arbiter_up_counter #(
        .MAX_COUNT(FRAME_CYCLES)
    ) u_frame_timer (
        .clk  (clk),
        .rst  (rst),
        .cen  (state == ST_WAIT),
        .init0(state == ST_SEND),
        .carry(frame_done)
    );

    // Frame sequencer; every output is a register updated alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            winner  <= '0;
            send    <= 1'b0;
            msg_out <= '0;
            grant   <= '0;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state   <= ST_SEND;
                        winner  <= pick;
                        grant   <= pick_onehot;
                        msg_out <= pick_msg;
                        send    <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                ST_SEND: begin
                    send  <= 1'b0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (frame_done) begin
                        state <= ST_DONE;
                        ack   <= grant;
                    end
                end
                ST_DONE: begin
                    ack   <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    ptr   <= (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// tb/tb_msg_tx_arbiter.sv - self-checking bench for msg_tx_arbiter
module tb_msg_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 5;
    localparam int MW = N * W;
    localparam int F  = 16;
    localparam int FF = 10240;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [MW-1:0] msg_in;
    logic          send;
    logic [W-1:0]  msg_out;
    logic [N-1:0]  grant;
    logic [N-1:0]  ack;
    logic          busy;

    logic [N-1:0]  req_f;
    logic [MW-1:0] msg_in_f;
    logic          send_f;
    logic [W-1:0]  msg_out_f;
    logic [N-1:0]  grant_f;
    logic [N-1:0]  ack_f;
    logic          busy_f;

    msg_tx_arbiter #(.N_REQ(N), .MSG_W(W), .FRAME_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .req(req), .msg_in(msg_in), .send(send),
        .msg_out(msg_out), .grant(grant), .ack(ack), .busy(busy)
    );

    msg_tx_arbiter #(.N_REQ(N), .MSG_W(W), .FRAME_CYCLES(FF)) dut_full (
        .clk(clk), .rst(rst), .req(req_f), .msg_in(msg_in_f), .send(send_f),
        .msg_out(msg_out_f), .grant(grant_f), .ack(ack_f), .busy(busy_f)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Transaction-level model: a frame is a start cycle and an owner
    bit           m_in_frame = 1'b0;
    int           m_start    = 0;
    int           m_owner    = 0;
    int           m_ptr      = 0;
    logic [W-1:0] m_msg      = '0;

    typedef struct {
        logic [N-1:0]  vreq;
        logic [MW-1:0] vmsg;
        logic [N-1:0]  exp_grant;
        logic [W-1:0]  exp_msg;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        logic [N-1:0] sh;
        for (int k = 0; k < N; k++) begin
            sh = r >> ((p + k) % N);
            if (sh[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] slice(input logic [MW-1:0] m, input int i);
        logic [MW-1:0] t;
        t = m >> (i * W);
        return t[W-1:0];
    endfunction

    task automatic model_edge();
        int p;
        if (rst) begin
            m_in_frame = 1'b0;
            m_ptr      = 0;
            m_msg      = '0;
        end else if (m_in_frame) begin
            if (cyc - m_start == F + 2) begin
                m_in_frame = 1'b0;
                m_ptr      = (m_owner + 1) % N;
            end
        end else begin
            p = rr_pick(m_ptr, req);
            if (p >= 0) begin
                m_in_frame = 1'b1;
                m_start    = cyc;
                m_owner    = p;
                m_msg      = slice(msg_in, p);
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg, ea;
        logic         es, eb;
        int           ph;
        eg = '0; ea = '0; es = 1'b0; eb = 1'b0;
        if (m_in_frame) begin
            ph = cyc - m_start;
            eg = N'(1) << m_owner;
            es = (ph == 0);
            eb = 1'b1;
            if (ph == F + 1) ea = eg;
        end
        chk("outputs{send,busy,grant,ack,msg_out}", {send, busy, grant, ack, msg_out},
            {es, eb, eg, ea, m_msg});
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {send, busy, grant, ack, msg_out}, '0);
        chk("async_reset_outputs_full", {send_f, busy_f, grant_f, ack_f, msg_out_f}, '0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_send(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit && at < 0; i++) begin
            step();
            if (send) at = cyc;
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL send_timeout: no send within %0d cycles (cycle %0d)", limit, cyc);
        end
    endtask

    task automatic wait_ack(input int limit, output int at, output logic [N-1:0] who);
        at  = -1;
        who = '0;
        for (int i = 0; i < limit && at < 0; i++) begin
            step();
            if (ack != '0) begin
                at  = cyc;
                who = ack;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL ack_timeout: no ack within %0d cycles (cycle %0d)", limit, cyc);
        end
    endtask

    initial begin
        int           s, a, prev, t0;
        logic [N-1:0] who;
        bit           seen;

        rst = 1'b0; req = '0; msg_in = '0; req_f = '0; msg_in_f = '0;
        vecs[0] = '{4'b0100, {5'd0, 5'b10110, 5'd0, 5'd0},          4'b0100, 5'b10110};
        vecs[1] = '{4'b0001, {5'd9, 5'd9, 5'd9, 5'b00011},          4'b0001, 5'b00011};
        vecs[2] = '{4'b1000, {5'b11111, 5'd2, 5'd3, 5'd4},          4'b1000, 5'b11111};
        vecs[3] = '{4'b0110, {5'd1, 5'b01010, 5'b10001, 5'd7},      4'b0010, 5'b10001};
        vecs[4] = '{4'b1010, {5'b11000, 5'd0, 5'b00111, 5'd0},      4'b0010, 5'b00111};
        #1;

        // Reset and quiet idle
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            msg_in = MW'($urandom());
            step();
            if (send) seen = 1'b1;
        end
        chk("idle_no_send", seen, 0);
        chk("idle_busy", busy, 0);

        // Single-request vectors from a fresh pointer
        for (int v = 0; v < 5; v++) begin
            do_reset();
            req    = vecs[v].vreq;
            msg_in = vecs[v].vmsg;
            t0     = cyc;
            wait_send(4, s);
            chk("vec_send_latency", s - t0, 1);
            chk("vec_grant", grant, vecs[v].exp_grant);
            chk("vec_msg_out", msg_out, vecs[v].exp_msg);
            wait_ack(F + 4, a, who);
            chk("vec_ack_delay", a - s, F + 1);
            chk("vec_ack_port", who, vecs[v].exp_grant);
            req = '0;
            step();
            step();
        end

        // Round robin with all ports requesting, each dropping on its ack
        do_reset();
        req    = 4'b1111;
        msg_in = MW'($urandom());
        prev   = 0;
        for (int k = 0; k < N; k++) begin
            wait_send(F + 8, s);
            chk("rr_grant_order", grant, N'(1) << k);
            if (k > 0) chk("rr_send_period", s - prev, F + 3);
            prev = s;
            wait_ack(F + 4, a, who);
            req = req & ~who;
        end
        step();

        // Pointer at 3 after serving port 2: port 0 wins before port 2
        do_reset();
        req = 4'b0100;
        wait_send(4, s);
        wait_ack(F + 4, a, who);
        req = 4'b0101;
        wait_send(6, s);
        chk("wrap_first_grant", grant, 4'b0001);
        wait_ack(F + 4, a, who);
        req = 4'b0100;
        wait_send(6, s);
        chk("wrap_second_grant", grant, 4'b0100);
        wait_ack(F + 4, a, who);
        req = '0;
        step();

        // Payload changes after capture do not reach msg_out
        do_reset();
        msg_in = {5'd3, 5'd6, 5'd12, 5'b10101};
        req    = 4'b0001;
        wait_send(4, s);
        chk("iso_capture", msg_out, 5'b10101);
        for (int i = 0; i < 3; i++) step();
        msg_in = {5'd3, 5'd6, 5'd12, 5'b00001};
        for (int i = 0; i < 5; i++) step();
        chk("iso_mid_wait", msg_out, 5'b10101);
        wait_ack(F + 4, a, who);
        chk("iso_at_ack", msg_out, 5'b10101);
        req = '0;
        step();

        // Reset mid-frame drops the frame and restarts the pointer at 0
        do_reset();
        req = 4'b0001;
        wait_send(4, s);
        wait_ack(F + 4, a, who);
        req = 4'b0011;
        wait_send(6, s);
        chk("mid_pre_grant", grant, 4'b0010);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        #1;
        chk("mid_async_clear", {send, busy, grant, ack, msg_out}, '0);
        step();
        rst  = 1'b0;
        seen = 1'b0;
        s    = -1;
        for (int i = 0; i < 4 && s < 0; i++) begin
            step();
            if (ack != '0) seen = 1'b1;
            if (send) s = cyc;
        end
        chk("mid_no_ack", seen, 0);
        chk("mid_regrant_seen", (s >= 0), 1);
        chk("mid_regrant_port0", grant, 4'b0001);
        wait_ack(F + 4, a, who);
        req = '0;
        step();

        // Randomized traffic against the model, with rare resets
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            req    = N'($urandom_range(0, 15));
            msg_in = MW'($urandom());
            rst    = ($urandom_range(0, 499) == 0);
            step();
            rst = 1'b0;
        end
        req = '0;
        step();

        // One full-length frame
        req_f    = 4'b0001;
        msg_in_f = {5'd0, 5'd0, 5'd0, 5'b11010};
        s = -1;
        for (int i = 0; i < 4 && s < 0; i++) begin
            step();
            if (send_f) s = cyc;
        end
        chk("full_send_seen", (s >= 0), 1);
        chk("full_msg_out", msg_out_f, 5'b11010);
        a = -1;
        for (int i = 0; i < FF + 10 && a < 0; i++) begin
            step();
            if (ack_f != '0) begin
                a   = cyc;
                who = ack_f;
            end
        end
        chk("full_ack_delay", a - s, FF + 1);
        chk("full_ack_port", who, 4'b0001);
        req_f = '0;
        step();
        step();
        chk("full_idle_after", busy_f, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
